// File: rtl/aws_tm_pkg.sv
// Definitions shared by the AWS timer event generator and its reader.
// The event word is {lock, timer value}; the timer counts 0..AWSTM_MAX.
package aws_tm_pkg;

   localparam logic [30:0] AWSTM_MAX    = 31'd999_999_999;
   localparam int          EVT_LOCK_BIT = 31;
   localparam int          EVT_W        = 32;

   typedef struct packed {
      logic        lock;
      logic [30:0] tm;
   } aws_evt_t;

   function automatic logic evt_lock(input logic [EVT_W-1:0] word);
      return word[EVT_LOCK_BIT];
   endfunction

endpackage

// File: rtl/aws_sync_fifo.sv
// Single-clock circular FIFO with a registered head-of-queue read port.
// The head register is loaded so that a word pushed into an empty FIFO shows up on the next cycle.
module aws_sync_fifo #(
   parameter int P_WIDTH = 32,
   parameter int P_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [P_WIDTH-1:0] wdata,
   input  logic               pop,
   output logic [P_WIDTH-1:0] rdata,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(P_DEPTH);
   localparam logic [AW:0] LEVEL_ONE = {{AW{1'b0}}, 1'b1};

   logic [P_WIDTH-1:0] mem [P_DEPTH];
   logic [AW:0]        wptr;
   logic [AW:0]        rptr;
   logic [AW:0]        rptr_inc;
   logic [AW:0]        level;
   logic               do_push;
   logic               do_pop;

   // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign level    = wptr - rptr;
   assign rptr_inc = rptr + LEVEL_ONE;
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         rdata <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + LEVEL_ONE;
         end
         if (do_pop) begin
            rptr <= rptr_inc;
         end
         // Head register follows mem[rptr]; a push into the slot becoming head bypasses memory.
         if (do_pop) begin
            if (level > LEVEL_ONE) begin
               rdata <= mem[rptr_inc[AW-1:0]];
            end else if (do_push) begin
               rdata <= wdata;
            end
         end else if (empty && do_push) begin
            rdata <= wdata;
         end
      end
   end

endmodule

// File: rtl/aws_evt_rx.sv
// Reader for the AWS timer event word: detects each new event, stamps it with the
// cycle interval since the previous one and queues it; also reports lock changes and drops.
module aws_evt_rx
   import aws_tm_pkg::*;
#(
   parameter int P_DEPTH  = 4,
   parameter int P_INTV_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [EVT_W-1:0]    evt,
   output logic [EVT_W-1:0]    tm_data,
   output logic [P_INTV_W-1:0] tm_intv,
   output logic                tm_valid,
   input  logic                tm_ready,
   output logic                lock,
   output logic                lock_lost,
   output logic                lock_gain,
   output logic                ovf,
   output logic [7:0]          drop_cnt,
   input  logic                ovf_clr
);

   // tm_data/tm_intv are valid while tm_valid is high and hold until tm_valid & tm_ready.
   localparam int ENTRY_W = EVT_W + P_INTV_W;
   localparam logic [P_INTV_W-1:0] INTV_ONE = {{(P_INTV_W-1){1'b0}}, 1'b1};

   aws_evt_t              r_evt;
   logic                  armed;
   logic [P_INTV_W-1:0]   r_intv;
   logic [P_INTV_W-1:0]   intv_push;
   logic                  new_evt;
   logic                  pop;
   logic                  drop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [ENTRY_W-1:0]    fifo_wdata;
   logic [ENTRY_W-1:0]    fifo_rdata;

   assign new_evt    = armed & (evt != r_evt);
   assign intv_push  = (&r_intv) ? r_intv : r_intv + INTV_ONE;
   assign tm_valid   = ~fifo_empty;
   assign pop        = tm_valid & tm_ready;
   assign drop       = new_evt & fifo_full & ~pop;
   assign fifo_wdata = {evt, intv_push};
   assign tm_data    = fifo_rdata[ENTRY_W-1 -: EVT_W];
   assign tm_intv    = fifo_rdata[P_INTV_W-1:0];

   aws_sync_fifo #(
      .P_WIDTH (ENTRY_W),
      .P_DEPTH (P_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (new_evt),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The first sampled word only seeds r_evt; armed keeps it out of the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_evt  <= '0;
         armed  <= 1'b0;
         r_intv <= '0;
      end else begin
         r_evt <= evt;
         armed <= 1'b1;
         if (new_evt) begin
            r_intv <= '0;
         end else if (!(&r_intv)) begin
            r_intv <= r_intv + INTV_ONE;
         end
      end
   end

   // Lock pulses are suppressed until armed, so the reset value of lock never causes one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock      <= 1'b0;
         lock_lost <= 1'b0;
         lock_gain <= 1'b0;
      end else begin
         lock      <= evt_lock(evt);
         lock_lost <= armed & lock & ~evt_lock(evt);
         lock_gain <= armed & ~lock & evt_lock(evt);
      end
   end

   // A drop in the same cycle as ovf_clr restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         ovf <= 1'b1;
         if (ovf_clr) begin
            drop_cnt <= 8'd1;
         end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end else if (ovf_clr) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_aws_evt_rx.sv
// Directed bench for aws_evt_rx: arming, periodic capture, overflow, lock pulses, mid-stream reset.
module tb_aws_evt_rx;

   logic        clk;
   logic        rst;
   logic [31:0] evt;
   logic [31:0] tm_data;
   logic [31:0] tm_intv;
   logic        tm_valid;
   logic        tm_ready;
   logic        lock;
   logic        lock_lost;
   logic        lock_gain;
   logic        ovf;
   logic [7:0]  drop_cnt;
   logic        ovf_clr;

   int checks = 0;
   int errors = 0;

   aws_evt_rx #(
      .P_DEPTH  (4),
      .P_INTV_W (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .evt       (evt),
      .tm_data   (tm_data),
      .tm_intv   (tm_intv),
      .tm_valid  (tm_valid),
      .tm_ready  (tm_ready),
      .lock      (lock),
      .lock_lost (lock_lost),
      .lock_gain (lock_gain),
      .ovf       (ovf),
      .drop_cnt  (drop_cnt),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at the falling edge; outputs are observed at the next falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [31:0] e);
      evt      = e;
      tm_ready = 1'b0;
      ovf_clr  = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      evt      = 32'hFFFF_FFFF;
      tm_ready = 1'b1;
      ovf_clr  = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      checks++; if (tm_data !== 32'h0) begin errors++; $display("FAIL rst_tm_data got %h exp 0", tm_data); end
      checks++; if (tm_intv !== 32'h0) begin errors++; $display("FAIL rst_tm_intv got %h exp 0", tm_intv); end
      checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL rst_tm_valid got %b exp 0", tm_valid); end
      checks++; if (lock !== 1'b0) begin errors++; $display("FAIL rst_lock got %b exp 0", lock); end
      checks++; if (lock_lost !== 1'b0 || lock_gain !== 1'b0) begin errors++; $display("FAIL rst_lock_pulse got %b%b exp 00", lock_lost, lock_gain); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop_cnt got %0d exp 0", drop_cnt); end
   endtask

   task automatic test_arming();
      do_reset(32'h8000_0000);
      for (int c = 1; c <= 10; c++) begin
         tick();
         checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL arm_idle_valid cyc %0d got %b exp 0", c, tm_valid); end
         checks++; if (lock_gain !== 1'b0) begin errors++; $display("FAIL arm_no_gain cyc %0d got %b exp 0", c, lock_gain); end
      end
      checks++; if (lock !== 1'b1) begin errors++; $display("FAIL arm_lock got %b exp 1", lock); end
      evt = 32'h8000_0064;
      tick();
      checks++; if (tm_valid !== 1'b1) begin errors++; $display("FAIL arm_valid got %b exp 1", tm_valid); end
      checks++; if (tm_data !== 32'h8000_0064) begin errors++; $display("FAIL arm_data got %h exp 80000064", tm_data); end
      checks++; if (tm_intv !== 32'd11) begin errors++; $display("FAIL arm_intv got %0d exp 11", tm_intv); end
      tm_ready = 1'b1;
      tick();
      checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL arm_pop_valid got %b exp 0", tm_valid); end
   endtask

   task automatic test_periodic();
      logic [31:0] w;
      do_reset(32'h8000_0000);
      tm_ready = 1'b1;
      repeat (4) tick();
      evt = 32'h8000_0000 + 32'd100;
      tick();
      checks++; if (tm_intv !== 32'd5) begin errors++; $display("FAIL per_first_intv got %0d exp 5", tm_intv); end
      for (int k = 2; k <= 5; k++) begin
         repeat (99) tick();
         checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL per_gap_valid k %0d got %b exp 0", k, tm_valid); end
         w   = 32'h8000_0000 + 32'(100 * k);
         evt = w;
         tick();
         checks++; if (tm_valid !== 1'b1) begin errors++; $display("FAIL per_valid k %0d got %b exp 1", k, tm_valid); end
         checks++; if (tm_data !== w) begin errors++; $display("FAIL per_data k %0d got %h exp %h", k, tm_data, w); end
         checks++; if (tm_intv !== 32'd100) begin errors++; $display("FAIL per_intv k %0d got %0d exp 100", k, tm_intv); end
      end
      tick();
   endtask

   task automatic test_overflow();
      logic [31:0] exp_intv;
      do_reset(32'h8000_0000);
      repeat (3) tick();
      for (int i = 1; i <= 6; i++) begin
         evt = 32'h8000_0000 + 32'(i);
         tick();
         if (i == 4) begin
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b exp 0", ovf); end
         end
      end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 2", drop_cnt); end
      checks++; if (tm_data !== 32'h8000_0001) begin errors++; $display("FAIL ovf_head_hold got %h exp 80000001", tm_data); end
      // A seventh drop coinciding with a clear: drop wins, count restarts at one.
      evt     = 32'h8000_0007;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clr_vs_drop_ovf got %b exp 1", ovf); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL clr_vs_drop_cnt got %0d exp 1", drop_cnt); end
      tm_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp_intv = (i == 1) ? 32'd4 : 32'd1;
         checks++; if (tm_data !== 32'h8000_0000 + 32'(i)) begin errors++; $display("FAIL drain_data %0d got %h exp %h", i, tm_data, 32'h8000_0000 + 32'(i)); end
         checks++; if (tm_intv !== exp_intv) begin errors++; $display("FAIL drain_intv %0d got %0d exp %0d", i, tm_intv, exp_intv); end
         tick();
      end
      checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", tm_valid); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL ovf_clr got %b/%0d exp 0/0", ovf, drop_cnt); end
      tm_ready = 1'b0;
      for (int i = 0; i < 304; i++) begin
         evt = 32'h8000_0100 + 32'(i);
         tick();
      end
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d exp 255", drop_cnt); end
   endtask

   task automatic test_full_push_pop();
      do_reset(32'h8000_0000);
      repeat (3) tick();
      for (int i = 1; i <= 4; i++) begin
         evt = 32'h8000_0000 + 32'(i);
         tick();
      end
      evt      = 32'h8000_0005;
      tm_ready = 1'b1;
      tick();
      tm_ready = 1'b0;
      checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL fpp_no_drop got %b/%0d exp 0/0", ovf, drop_cnt); end
      checks++; if (tm_data !== 32'h8000_0002) begin errors++; $display("FAIL fpp_head got %h exp 80000002", tm_data); end
      evt = 32'h8000_0006;
      tick();
      checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL fpp_still_full got %b/%0d exp 1/1", ovf, drop_cnt); end
      tm_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         checks++; if (tm_valid !== 1'b1 || tm_data !== 32'h8000_0000 + 32'(i)) begin errors++; $display("FAIL fpp_drain %0d got %b/%h exp 1/%h", i, tm_valid, tm_data, 32'h8000_0000 + 32'(i)); end
         tick();
      end
      checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %b exp 0", tm_valid); end
   endtask

   task automatic test_lock();
      do_reset(32'h8000_1000);
      tm_ready = 1'b1;
      repeat (3) tick();
      evt = 32'h0000_1000;
      tick();
      checks++; if (lock_lost !== 1'b1 || lock_gain !== 1'b0) begin errors++; $display("FAIL lost_pulse got %b%b exp 10", lock_lost, lock_gain); end
      checks++; if (lock !== 1'b0) begin errors++; $display("FAIL lost_lock got %b exp 0", lock); end
      checks++; if (tm_valid !== 1'b1 || tm_data !== 32'h0000_1000) begin errors++; $display("FAIL lost_evt got %b/%h exp 1/00001000", tm_valid, tm_data); end
      tick();
      checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL lost_one_cycle got %b exp 0", lock_lost); end
      evt = 32'h8000_1000;
      tick();
      checks++; if (lock_gain !== 1'b1 || lock_lost !== 1'b0) begin errors++; $display("FAIL gain_pulse got %b%b exp 01", lock_lost, lock_gain); end
      checks++; if (lock !== 1'b1 || tm_data !== 32'h8000_1000) begin errors++; $display("FAIL gain_evt got %b/%h exp 1/80001000", lock, tm_data); end
      tick();
      checks++; if (lock_gain !== 1'b0) begin errors++; $display("FAIL gain_one_cycle got %b exp 0", lock_gain); end
   endtask

   task automatic test_mid_reset();
      do_reset(32'h8000_0000);
      repeat (3) tick();
      for (int i = 1; i <= 3; i++) begin
         evt = 32'h8000_0010 + 32'(i);
         tick();
      end
      checks++; if (tm_valid !== 1'b1) begin errors++; $display("FAIL mrst_queued got %b exp 1", tm_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL mrst_async_valid got %b exp 0", tm_valid); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mrst_ovf got %b exp 0", ovf); end
      repeat (3) tick();
      checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL mrst_no_stale got %b exp 0", tm_valid); end
      evt = 32'h8000_0099;
      tick();
      checks++; if (tm_data !== 32'h8000_0099 || tm_intv !== 32'd4) begin errors++; $display("FAIL mrst_first got %h/%0d exp 80000099/4", tm_data, tm_intv); end
      tm_ready = 1'b1;
      tick();
      checks++; if (tm_valid !== 1'b0) begin errors++; $display("FAIL mrst_single got %b exp 0", tm_valid); end
   endtask

   initial begin
      rst      = 1'b1;
      evt      = '0;
      tm_ready = 1'b0;
      ovf_clr  = 1'b0;
      @(negedge clk);
      test_reset();
      test_arming();
      test_periodic();
      test_overflow();
      test_full_push_pop();
      test_lock();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aws_evt_rx.md
# aws_evt_rx

Reader-side counterpart of the AWS timer event generator. Samples the 32-bit event word `{lock, awstm[30:0]}` that the timer block updates on every timer event. Detects each new event and queues it, with a cycle-stamped interval measurement, into a small FIFO. The FIFO is drained by the PS-side logic over a valid/ready handshake. It also reports PPS-lock transitions and FIFO overflow for interrupt generation.

## Interface
- `P_DEPTH`, 4: FIFO depth in entries; power of two, 2..16.
- `P_INTV_W`, 32: width of the inter-event cycle counter.
- `clk` in 1: fabric clock, same clock as the event generator (fclk0, 100 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `evt` in 32: event word; bit 31 is the lock flag, bits 30:0 are the timer value (0..999_999_999).
- `tm_data` out 32: head-of-FIFO event word.
- `tm_intv` out P_INTV_W: cycles elapsed between this event and the previous captured event.
- `tm_valid` out 1: the FIFO head is valid.
- `tm_ready` in 1: consumer accepts the head when `tm_valid & tm_ready`.
- `lock` out 1: registered copy of `evt[31]`.
- `lock_lost` out 1: one-cycle pulse on a lock 1→0 transition.
- `lock_gain` out 1: one-cycle pulse on a lock 0→1 transition.
- `ovf` out 1: sticky flag, set when an event is dropped because the FIFO is full.
- `drop_cnt` out 8: number of dropped events; saturates at 255.
- `ovf_clr` in 1: synchronous clear of `ovf` and `drop_cnt`.

## Operation
- **Sampling:** `r_evt <= evt` every cycle.
- **New event:** `new_evt = armed & (evt != r_evt)`. A change in only the lock bit also counts as an event.
- **Arming:** `armed` is cleared by reset and set on the first clock after reset. The first sampled word is never queued.
- **Interval counter:** `r_intv` increments every cycle and saturates at all-ones.
  - On `new_evt`, the pushed `tm_intv` equals `r_intv + 1`, and `r_intv` restarts at 0.
  - The counter runs from reset, so the first captured event reports cycles since reset.
- **Push:** on `new_evt`, the entry `{evt, intv}` is written.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped, `ovf <= 1`, and `drop_cnt` increments unless already 255.
- **Pop:** occurs when `tm_valid & tm_ready`.
  - If a push and a pop happen in the same cycle when the FIFO is full, both succeed and there is no overflow.
  - A push and a pop in the same cycle when the FIFO is empty are impossible, because there is no fall-through.
- **`ovf_clr` precedence:** if `ovf_clr` coincides with a drop, the drop wins: `ovf = 1` and `drop_cnt = 1`.
- **Lock tracking:**
  - `lock <= evt[31]` is updated every cycle, independent of `armed`.
  - `lock_lost` is high for the cycle after `lock` goes 1→0; `lock_gain` likewise for 0→1.
  - No lock pulse is generated on the first cycle after reset.
- **Timer wrap:** a wrap from 999_999_9xx to a small value is an ordinary change; no special handling.
- **FIFO storage:** a circular buffer with read/write pointers one bit wider than the address. Full and empty are derived from the pointers.

## Timing
- **Reset values:** `tm_data` = 0, `tm_intv` = 0, `tm_valid` = 0, `lock` = 0, `lock_lost` = 0, `lock_gain` = 0, `ovf` = 0, `drop_cnt` = 0. All pointers, `r_intv`, and `armed` are also cleared.
- **Latency:** `evt` changes before edge N. `new_evt` is evaluated at edge N, where the push occurs. `tm_valid` rises and `tm_data` presents the word after edge N if the FIFO was empty.
- **Outputs:** `tm_data` and `tm_intv` are registered (FIFO read port plus output register), with no combinational path from `evt`. They hold stable while `tm_valid & !tm_ready`.
- **Throughput:** one push and one pop per cycle. Back-to-back `evt` changes in consecutive cycles are each captured.
- **Reset during operation:** asynchronous reset empties the FIFO immediately. Queued events are lost; `ovf` is not set.

## Structure
- **Shared package `aws_tm_pkg`:**
  - `AWSTM_MAX` = 999_999_999.
  - `EVT_LOCK_BIT` = 31.
  - Event-word typedef `{lock, tm[30:0]}`, reused by the generator and this block.
- **Sub-module `aws_sync_fifo`:** parameterised width and depth, `push`, `pop`, `full`, `empty`, registered read data. It is instantiated here with width 32+P_INTV_W.

## Test plan
- **Arming:** after reset, hold `evt` = 0x8000_0000 steady → no push, `tm_valid` stays 0. Then change to 0x8000_0064 at cycle 10 → `tm_valid` = 1 after that edge, `tm_data` = 0x8000_0064, `tm_intv` = 11.
- **Periodic events:** `evt` steps by 100 every 100 cycles, `tm_ready` = 1 → each pop shows `tm_intv` = 100 and consecutive `tm_data` values.
- **Overflow:** `tm_ready` = 0 for 6 events with P_DEPTH = 4 → 4 entries queued, `ovf` = 1, `drop_cnt` = 2. Drain → the first 4 words come out in order. `ovf_clr` → `ovf` = 0, `drop_cnt` = 0.
- **Full with simultaneous push and pop:** FIFO full, `tm_ready` = 1 in the same cycle as a new event → no drop, occupancy stays 4.
- **Lock transitions:** `evt` 0x8000_1000 → 0x0000_1000 → `lock_lost` is a one-cycle pulse, the event is queued with bit 31 = 0, and `lock` = 0. The reverse transition gives a `lock_gain` pulse.
- **Mid-stream reset:** 3 queued entries, assert `rst` for 2 cycles → `tm_valid` = 0 immediately, and the next `evt` change after re-arming is the first entry out.
